// File: rtl/rf_write_scheduler.sv
// Write-back scheduler: round-robin merge of ALU/load results
// onto the single RF write port, plus pending-write scoreboard.
module rf_write_scheduler #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] rd1_reg,
  input  logic [ADDR_W-1:0] rd2_reg,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int NREG = 1 << ADDR_W;

  logic              gnt_a;
  logic              gnt_b;
  logic              hs;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              last_b_q;
  logic              last_b_d;
  logic              rf_we_q;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [ADDR_W-1:0] rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [DATA_W-1:0] rf_wdata_d;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Round-robin grant; a tie goes to the source not granted last
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        gnt_a = last_b_q;
        gnt_b = !last_b_q;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  assign hs       = gnt_a | gnt_b;
  assign sel_reg  = gnt_a ? a_reg  : b_reg;
  assign sel_data = gnt_a ? a_data : b_data;

  // Commit register, round-robin pointer and scoreboard update
  always_comb begin
    last_b_d   = last_b_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    if (hs) begin
      last_b_d   = gnt_b;
      rf_we_d    = (sel_reg != '0);
      rf_waddr_d = sel_reg;
      rf_wdata_d = sel_data;
    end
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid && (issue_reg != '0)) begin
      busy_d[issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; last resets to B so A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q   <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      last_b_q   <= last_b_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign stall    = busy_q[rd1_reg] | busy_q[rd2_reg];
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
